// File: rtl/pic_ram_loader_pkg.sv
// Shared picture-store constants and loader FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pic_ram_loader_pkg;

   // Picture RAM geometry and framing, shared with pic_ram and the LCD scan logic
   localparam int          PIC_ADDR_W    = 9;
   localparam int          PIC_DEPTH     = 512;
   localparam logic [7:0]  PIC_SYNC_BYTE = 8'hA5;

   // RGB565 field positions inside a 16-bit pixel
   localparam int RGB565_R_MSB = 15;
   localparam int RGB565_R_LSB = 11;
   localparam int RGB565_G_MSB = 10;
   localparam int RGB565_G_LSB = 5;
   localparam int RGB565_B_MSB = 4;
   localparam int RGB565_B_LSB = 0;

   // Loader FSM: waiting for sync, expecting high byte, expecting low byte
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HI   = 2'd1,
      ST_LO   = 2'd2
   } ldr_state_t;

endpackage

// File: rtl/pic_ram_loader_rx_timeout_cnt.sv
// Inter-byte gap counter: flags when TIMEOUT-1 idle cycles have elapsed.
// Latency: expired is combinational from the registered count.
// Backpressure: none; clr dominates en.
module rx_timeout_cnt #(
   parameter int TIMEOUT = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int               CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   assign expired = en && (cnt == LIMIT);

   // Count idle cycles while enabled; stop at the limit, restart on clear
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pic_ram_loader.sv
// Assembles a sync-prefixed byte stream into RGB565 pixels and writes them to picture RAM.
// Latency: wr_en/wr_addr/wr_data 1 clk after the low-byte strobe; frame_done with last write.
// Backpressure: none; one byte per rx_valid strobe, dropped only on abort or timeout.
module pic_ram_loader
   import pic_ram_loader_pkg::*;
#(
   parameter int         ADDR_W    = PIC_ADDR_W,
   parameter int         DATA_W    = 16,
   parameter int         DEPTH     = PIC_DEPTH,
   parameter logic [7:0] SYNC_BYTE = PIC_SYNC_BYTE,
   parameter int         TIMEOUT   = 50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              abort,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_err
);

   // One extra bit so DEPTH == 2**ADDR_W never wraps before the last pixel
   localparam logic [ADDR_W:0] LAST_PIX = (ADDR_W + 1)'(DEPTH - 1);

   ldr_state_t      state, state_nxt;
   logic [ADDR_W:0] pix_cnt;
   logic [7:0]      hi_byte;
   logic            frame_start, take_hi, take_lo, last_px, err;
   logic            to_clr, to_en, to_expired;

   // Gap timer runs only inside a frame and restarts on every received byte
   assign to_clr = rx_valid || (state == ST_IDLE);
   assign to_en  = (state != ST_IDLE);
   assign busy   = (state != ST_IDLE);

   rx_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (to_clr),
      .en      (to_en),
      .expired (to_expired)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and per-cycle actions; priority is abort, then byte, then timeout
   always_comb begin
      state_nxt   = state;
      frame_start = 1'b0;
      take_hi     = 1'b0;
      take_lo     = 1'b0;
      last_px     = 1'b0;
      err         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
               state_nxt   = ST_HI;
               frame_start = 1'b1;
            end
         end
         ST_HI: begin
            if (abort) begin
               state_nxt = ST_IDLE;
               err       = 1'b1;
            end else if (rx_valid) begin
               state_nxt = ST_LO;
               take_hi   = 1'b1;
            end else if (to_expired) begin
               state_nxt = ST_IDLE;
               err       = 1'b1;
            end
         end
         ST_LO: begin
            if (abort) begin
               state_nxt = ST_IDLE;
               err       = 1'b1;
            end else if (rx_valid) begin
               take_lo   = 1'b1;
               last_px   = (pix_cnt == LAST_PIX);
               state_nxt = last_px ? ST_IDLE : ST_HI;
            end else if (to_expired) begin
               state_nxt = ST_IDLE;
               err       = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Pixel assembly, write port registers and status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         pix_cnt    <= '0;
         hi_byte    <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         wr_en      <= take_lo;
         frame_done <= take_lo && last_px;
         frame_err  <= err;
         if (frame_start) begin
            pix_cnt <= '0;
         end
         if (take_hi) begin
            hi_byte <= rx_data;
         end
         if (take_lo) begin
            wr_data <= {hi_byte, rx_data};
            wr_addr <= pix_cnt[ADDR_W-1:0];
            pix_cnt <= pix_cnt + 1'b1;
         end
      end
   end

endmodule
